id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/dlx_pkg.sv | 23 ++
 rtl/id_ex_stage_if.sv | 13 +
 rtl/id_ex_stage_fwd_mux.sv | 27 ++
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX pipeline widths and ALU function codes.
// Every pipeline stage imports this so encodings never drift between stages.
package dlx_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int FUNC_W = 6;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_SLL  = 6'b000100,
    FUNC_MULT = 6'b001110,
    FUNC_ADD  = 6'b100000,
    FUNC_SUB  = 6'b100010,
    FUNC_AND  = 6'b100100,
    FUNC_OR   = 6'b100101,
    FUNC_XOR  = 6'b100110,
    FUNC_SLT  = 6'b101010
  } alu_func_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// One forwarding source (a later pipeline register that will write rd).
// The producing stage drives the master side; consumers read through slave.
interface fwd_src_if #(
  parameter int DATA_W = dlx_pkg::DATA_W,
  parameter int REG_AW = dlx_pkg::REG_AW
);
  logic [REG_AW-1:0] rd;
  logic              wr_en;
  logic [DATA_W-1:0] result;

  modport master (output rd, wr_en, result);
  modport slave  (input  rd, wr_en, result);
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one source register of the EX stage.
// The younger EX/MEM producer wins over MEM/WB; register 0 is never forwarded.
module fwd_mux #(
  parameter int DATA_W = dlx_pkg::DATA_W,
  parameter int REG_AW = dlx_pkg::REG_AW
) (
  input  logic              valid_i,
  input  logic [REG_AW-1:0] idx_i,
  input  logic [DATA_W-1:0] reg_val_i,
  fwd_src_if.slave          exmem,
  fwd_src_if.slave          memwb,
  output logic [DATA_W-1:0] val_o
);

  // NOTE: val_o gets its default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    val_o = reg_val_i;
    if (valid_i && idx_i != '0) begin
      if (exmem.wr_en && exmem.rd == idx_i) begin
        val_o = exmem.result;
      end else if (memwb.wr_en && memwb.rd == idx_i) begin
        val_o = memwb.result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, write-through
// bypass at capture and zero-latency EX operand forwarding.
module id_ex_stage import dlx_pkg::*; #(
  parameter int DATA_W = dlx_pkg::DATA_W,
  parameter int REG_AW = dlx_pkg::REG_AW,
  parameter int FUNC_W = dlx_pkg::FUNC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_rs1_val,
  input  logic [DATA_W-1:0] in_rs2_val,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wr_en,
  input  logic              in_is_load,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_wr_en,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_wr_en,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_d1,
  output logic [DATA_W-1:0] alu_d2,
  output logic [FUNC_W-1:0] alu_func,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_wr_en,
  output logic              ex_is_load,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              load_use_stall
);

  fwd_src_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) exmem_src ();
  fwd_src_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) memwb_src ();

  assign exmem_src.rd     = exmem_rd;
  assign exmem_src.wr_en  = exmem_wr_en;
  assign exmem_src.result = exmem_result;
  assign memwb_src.rd     = memwb_rd;
  assign memwb_src.wr_en  = memwb_wr_en;
  assign memwb_src.result = memwb_result;

  logic              valid_q,   valid_d;
  logic [FUNC_W-1:0] func_q,    func_d;
  logic [REG_AW-1:0] rs1_q,     rs1_d;
  logic [REG_AW-1:0] rs2_q,     rs2_d;
  logic [DATA_W-1:0] rs1_val_q, rs1_val_d;
  logic [DATA_W-1:0] rs2_val_q, rs2_val_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic              use_imm_q, use_imm_d;
  logic [REG_AW-1:0] rd_q,      rd_d;
  logic              wr_en_q,   wr_en_d;
  logic              is_load_q, is_load_d;

  logic              insert_bubble;
  logic [DATA_W-1:0] rs1_byp, rs2_byp;
  logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

  // A load in EX cannot feed the instruction behind it without one bubble.
  assign load_use_stall = in_valid && valid_q && is_load_q && (rd_q != '0) &&
                          ((rd_q == in_rs1) || ((rd_q == in_rs2) && !in_use_imm));

  assign insert_bubble = flush || load_use_stall || !in_valid;

  // The register file is written at the end of WB, so a same-cycle read is stale.
  assign rs1_byp = (memwb_wr_en && memwb_rd != '0 && memwb_rd == in_rs1) ? memwb_result : in_rs1_val;
  assign rs2_byp = (memwb_wr_en && memwb_rd != '0 && memwb_rd == in_rs2) ? memwb_result : in_rs2_val;

  always_comb begin
    valid_d   = valid_q;
    func_d    = func_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    rd_d      = rd_q;
    wr_en_d   = wr_en_q;
    is_load_d = is_load_q;
    if (!stall) begin
      if (insert_bubble) begin
        valid_d   = 1'b0;
        func_d    = FUNC_ADD;
        rs1_d     = '0;
        rs2_d     = '0;
        rs1_val_d = '0;
        rs2_val_d = '0;
        imm_d     = '0;
        use_imm_d = 1'b0;
        rd_d      = '0;
        wr_en_d   = 1'b0;
        is_load_d = 1'b0;
      end else begin
        valid_d   = 1'b1;
        func_d    = in_func;
        rs1_d     = in_rs1;
        rs2_d     = in_rs2;
        rs1_val_d = rs1_byp;
        rs2_val_d = rs2_byp;
        imm_d     = in_imm;
        use_imm_d = in_use_imm;
        rd_d      = in_rd;
        wr_en_d   = in_wr_en;
        is_load_d = in_is_load;
      end
    end
  end

  // NOTE: every field, data included, is reset so no in-flight operand survives a reset.
  // NOTE: sequential state uses <= so all fields update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      func_q    <= FUNC_ADD;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      func_q    <= func_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      rd_q      <= rd_d;
      wr_en_q   <= wr_en_d;
      is_load_q <= is_load_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
    .valid_i   (valid_q),
    .idx_i     (rs1_q),
    .reg_val_i (rs1_val_q),
    .exmem     (exmem_src),
    .memwb     (memwb_src),
    .val_o     (fwd_rs1)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
    .valid_i   (valid_q),
    .idx_i     (rs2_q),
    .reg_val_i (rs2_val_q),
    .exmem     (exmem_src),
    .memwb     (memwb_src),
    .val_o     (fwd_rs2)
  );

  assign ex_valid      = valid_q;
  assign alu_func      = func_q;
  assign ex_rd         = rd_q;
  assign ex_wr_en      = wr_en_q;
  assign ex_is_load    = is_load_q;
  assign alu_d1        = fwd_rs1;
  assign alu_d2        = use_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios then random traffic,
// checked against an instruction-level model of the EX slot.
module tb_id_ex_stage;
  import dlx_pkg::*;

  typedef struct {
    logic rst, stall, flush, in_valid;
    logic [5:0] func;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val, imm;
    logic use_imm, wr_en, is_load;
    logic [4:0] xm_rd;  logic xm_we;  logic [31:0] xm_res;
    logic [4:0] mw_rd;  logic mw_we;  logic [31:0] mw_res;
  } stim_t;

  // The instruction currently sitting in EX, as the architecture sees it.
  typedef struct {
    logic valid;
    logic [5:0] func;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    logic use_imm, wr_en, is_load;
  } slot_t;

  typedef struct {
    logic ex_valid;
    logic [31:0] d1, d2, sd;
    logic [5:0] func;
    logic [4:0] rd;
    logic wr_en, is_load, lus;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush, in_valid, in_use_imm, in_wr_en, in_is_load;
  logic [5:0] in_func;
  logic [4:0] in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic ex_valid, ex_wr_en, ex_is_load, load_use_stall;
  logic [31:0] alu_d1, alu_d2, ex_store_data;
  logic [5:0] alu_func;
  logic [4:0] ex_rd;

  fwd_src_if exmem_if ();
  fwd_src_if memwb_if ();

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_func(in_func), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rd(in_rd), .in_wr_en(in_wr_en), .in_is_load(in_is_load),
    .stall(stall), .flush(flush),
    .exmem_rd(exmem_if.rd), .exmem_wr_en(exmem_if.wr_en), .exmem_result(exmem_if.result),
    .memwb_rd(memwb_if.rd), .memwb_wr_en(memwb_if.wr_en), .memwb_result(memwb_if.result),
    .ex_valid(ex_valid), .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_func(alu_func),
    .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  int total = 0;
  int bad   = 0;
  exp_t  sb_q[$];
  slot_t model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic slot_t bubble_slot();
    slot_t b;
    b = '{valid: 1'b0, func: FUNC_ADD, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, v1: 32'd0,
          v2: 32'd0, imm: 32'd0, use_imm: 1'b0, wr_en: 1'b0, is_load: 1'b0};
    return b;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{rst: 1'b0, stall: 1'b0, flush: 1'b0, in_valid: 1'b0, func: FUNC_ADD,
          rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rs1_val: 32'd0, rs2_val: 32'd0, imm: 32'd0,
          use_imm: 1'b0, wr_en: 1'b0, is_load: 1'b0,
          xm_rd: 5'd0, xm_we: 1'b0, xm_res: 32'd0, mw_rd: 5'd0, mw_we: 1'b0, mw_res: 32'd0};
    return s;
  endfunction

  // Architectural value of register r: the youngest pending write wins, r0 is always stale.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] stale,
                                         input logic incl_exmem, input stim_t s);
    logic [31:0] v;
    v = stale;
    if (r != 5'd0) begin
      if (s.mw_we && s.mw_rd == r) v = s.mw_res;
      if (incl_exmem && s.xm_we && s.xm_rd == r) v = s.xm_res;
    end
    return v;
  endfunction

  function automatic exp_t expect_out(input slot_t sl, input stim_t s);
    exp_t e;
    logic [31:0] op1, op2;
    op1 = sl.valid ? newest(sl.rs1, sl.v1, 1'b1, s) : sl.v1;
    op2 = sl.valid ? newest(sl.rs2, sl.v2, 1'b1, s) : sl.v2;
    e.ex_valid = sl.valid;
    e.func     = sl.func;
    e.rd       = sl.rd;
    e.wr_en    = sl.wr_en;
    e.is_load  = sl.is_load;
    e.d1       = op1;
    e.d2       = sl.use_imm ? sl.imm : op2;
    e.sd       = op2;
    e.lus      = s.in_valid && sl.valid && sl.is_load && sl.rd != 5'd0 &&
                 (sl.rd == s.rs1 || (sl.rd == s.rs2 && !s.use_imm));
    return e;
  endfunction

  function automatic slot_t next_slot(input slot_t sl, input stim_t s, input logic lus);
    slot_t n;
    if (s.rst) n = bubble_slot();
    else if (s.stall) n = sl;
    else if (s.flush || lus || !s.in_valid) n = bubble_slot();
    else begin
      n = '{valid: 1'b1, func: s.func, rs1: s.rs1, rs2: s.rs2, rd: s.rd,
            v1: newest(s.rs1, s.rs1_val, 1'b0, s), v2: newest(s.rs2, s.rs2_val, 1'b0, s),
            imm: s.imm, use_imm: s.use_imm, wr_en: s.wr_en, is_load: s.is_load};
    end
    return n;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; stall = s.stall; flush = s.flush; in_valid = s.in_valid;
    in_func = s.func; in_rs1 = s.rs1; in_rs2 = s.rs2; in_rd = s.rd;
    in_rs1_val = s.rs1_val; in_rs2_val = s.rs2_val; in_imm = s.imm;
    in_use_imm = s.use_imm; in_wr_en = s.wr_en; in_is_load = s.is_load;
    exmem_if.rd = s.xm_rd; exmem_if.wr_en = s.xm_we; exmem_if.result = s.xm_res;
    memwb_if.rd = s.mw_rd; memwb_if.wr_en = s.mw_we; memwb_if.result = s.mw_res;
  endtask

  // One pipeline cycle: present inputs just after the edge, record what EX must show.
  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    e = expect_out(model, s);
    sb_q.push_back(e);
    model = next_slot(model, s, e.lus);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("ex_valid",       32'(ex_valid),       32'(e.ex_valid));
      check("alu_d1",         alu_d1,              e.d1);
      check("alu_d2",         alu_d2,              e.d2);
      check("ex_store_data",  ex_store_data,       e.sd);
      check("alu_func",       32'(alu_func),       32'(e.func));
      check("ex_rd",          32'(ex_rd),          32'(e.rd));
      check("ex_wr_en",       32'(ex_wr_en),       32'(e.wr_en));
      check("ex_is_load",     32'(ex_is_load),     32'(e.is_load));
      check("load_use_stall", 32'(load_use_stall), 32'(e.lus));
    end
  end

  logic [5:0] func_pool [8] = '{FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR,
                                FUNC_XOR, FUNC_SLT, FUNC_SLL, FUNC_MULT};

  initial begin
    stim_t s;
    s = nop();
    s.rst = 1'b1;
    apply(s);
    model = bubble_slot();
    drive(s);
    #2;
    check("reset_alu_func", 32'(alu_func), 32'h20);
    check("reset_ex_valid", 32'(ex_valid), 32'h0);

    // EX/MEM result forwarded with zero added latency
    s = nop(); s.in_valid = 1; s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd3; s.wr_en = 1;
    drive(s);
    s = nop(); s.xm_rd = 5'd1; s.xm_we = 1; s.xm_res = 32'h10;
    drive(s); #2;
    check("fwd_exmem_d1", alu_d1, 32'h10);

    // EX/MEM beats MEM/WB; a write to r0 is never forwarded
    s = nop(); s.in_valid = 1; s.rs1 = 5'd1; s.rs1_val = 32'h5; s.rd = 5'd4; s.wr_en = 1;
    drive(s);
    s = nop(); s.xm_rd = 5'd1; s.xm_we = 1; s.xm_res = 32'hAA;
    s.mw_rd = 5'd1; s.mw_we = 1; s.mw_res = 32'hBB;
    s.in_valid = 1; s.rs1 = 5'd0; s.rs1_val = 32'h77; s.rd = 5'd4; s.wr_en = 1;
    drive(s); #2;
    check("fwd_priority_d1", alu_d1, 32'hAA);
    s = nop(); s.xm_rd = 5'd0; s.xm_we = 1; s.xm_res = 32'hFF;
    drive(s); #2;
    check("no_fwd_r0_d1", alu_d1, 32'h77);

    // load-use: one bubble, then the held instruction enters EX
    s = nop(); s.in_valid = 1; s.rd = 5'd5; s.wr_en = 1; s.is_load = 1;
    drive(s);
    s = nop(); s.in_valid = 1; s.rs1 = 5'd5; s.rd = 5'd6; s.wr_en = 1;
    drive(s); #2;
    check("load_use_stall_hi", 32'(load_use_stall), 32'h1);
    drive(s); #2;
    check("load_use_bubble", 32'(ex_valid), 32'h0);
    check("load_use_released", 32'(load_use_stall), 32'h0);
    drive(nop()); #2;
    check("load_use_captured_rd", 32'(ex_rd), 32'h6);

    // flush squashes; stall outranks flush
    s = nop(); s.in_valid = 1; s.rd = 5'd7; s.wr_en = 1; s.flush = 1;
    drive(s);
    s = nop(); s.in_valid = 1; s.func = FUNC_MULT; s.rd = 5'd8; s.wr_en = 1;
    drive(s); #2;
    check("flush_wr_en", 32'(ex_wr_en), 32'h0);
    s = nop(); s.in_valid = 1; s.rd = 5'd9; s.wr_en = 1; s.stall = 1; s.flush = 1;
    drive(s); #2;
    check("mult_passthrough", 32'(alu_func), 32'h0E);
    drive(nop()); #2;
    check("stall_holds_rd", 32'(ex_rd), 32'h8);

    // write-through bypass at capture
    s = nop(); s.in_valid = 1; s.rs2 = 5'd2; s.rs2_val = 32'h0; s.rd = 5'd3; s.wr_en = 1;
    s.mw_rd = 5'd2; s.mw_we = 1; s.mw_res = 32'h1234;
    drive(s);
    drive(nop()); #2;
    check("bypass_d2", alu_d2, 32'h1234);

    // reset with stall discards the in-flight instruction
    s = nop(); s.in_valid = 1; s.func = FUNC_SUB; s.rs1_val = 32'hDEAD; s.rd = 5'd4; s.wr_en = 1;
    drive(s);
    s = nop(); s.rst = 1; s.stall = 1;
    drive(s);
    drive(nop()); #2;
    check("rst_mid_d1", alu_d1, 32'h0);
    check("rst_mid_func", 32'(alu_func), 32'h20);

    for (int i = 0; i < 600; i++) begin
      s.rst      = ($urandom_range(0, 99) < 3);
      s.stall    = ($urandom_range(0, 99) < 15);
      s.flush    = ($urandom_range(0, 99) < 10);
      s.in_valid = ($urandom_range(0, 99) < 80);
      s.func     = func_pool[$urandom_range(0, 7)];
      s.rs1      = 5'($urandom_range(0, 7));
      s.rs2      = 5'($urandom_range(0, 7));
      s.rd       = 5'($urandom_range(0, 7));
      s.rs1_val  = $urandom;
      s.rs2_val  = $urandom;
      s.imm      = $urandom;
      s.use_imm  = ($urandom_range(0, 99) < 40);
      s.wr_en    = ($urandom_range(0, 99) < 70);
      s.is_load  = ($urandom_range(0, 99) < 30);
      s.xm_rd    = 5'($urandom_range(0, 7));
      s.xm_we    = ($urandom_range(0, 99) < 60);
      s.xm_res   = $urandom;
      s.mw_rd    = 5'($urandom_range(0, 7));
      s.mw_we    = ($urandom_range(0, 99) < 60);
      s.mw_res   = $urandom;
      drive(s);
    end

    drive(nop());
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
